// File: rtl/logic_muxn_rr.sv
// N-channel registered mux, fixed-select or round-robin, valid/ready on all ports.
// Optional out_parity port enabled by defining LOGIC_MUXN_PARITY_EN.
module logic_muxn_rr #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 3,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef LOGIC_MUXN_PARITY_EN
  ,
  output logic                      out_parity
`endif
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] g;
  logic             gnt;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] g_data;
  logic             g_valid;

  assign load = !out_valid || out_ready;

  // Grant: fixed index, or first valid channel at/after rr_ptr with wrap
  always_comb begin
    int idx;
    g   = '0;
    gnt = 1'b0;
    idx = 0;
    if (mode) begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!gnt && in_valid[idx]) begin
          gnt = 1'b1;
          g   = SEL_W'(idx);
        end
      end
    end else begin
      g   = sel;
      gnt = 32'(sel) < 32'(CHANNELS);
    end
  end

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(g) == i) begin
        g_data  = in_data[i*WIDTH +: WIDTH];
        g_valid = in_valid[i];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = !rst && load && gnt && (int'(g) == i);
    end
  end

  assign xfer = load && gnt && g_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (xfer) begin
        out_data  <= g_data;
        out_ch    <= g;
        out_valid <= 1'b1;
        if (mode) begin
          rr_ptr <= (int'(g) == CHANNELS - 1) ? '0 : g + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_MUXN_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (xfer) begin
      out_parity <= ^g_data;
    end
  end
`endif

endmodule

// File: tb/tb_logic_muxn_rr.sv
// Scoreboard bench for logic_muxn_rr (WIDTH=3, CHANNELS=3).
// Directed vectors; a negedge monitor checks every accepted output word.
module tb_logic_muxn_rr;

  localparam int W = 3;
  localparam int C = 3;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [S-1:0] sel;
  logic [C*W-1:0] in_data;
  logic [C-1:0] in_valid;
  logic [C-1:0] in_ready;
  logic [W-1:0] out_data;
  logic [S-1:0] out_ch;
  logic         out_valid;
  logic         out_ready;
`ifdef LOGIC_MUXN_PARITY_EN
  logic         out_parity;
`endif

  logic_muxn_rr #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .sel(sel),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef LOGIC_MUXN_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [S-1:0] ch;
    logic         par;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic [S-1:0] c,
                      input logic p);
    exp_t e;
    e.data = d;
    e.ch   = c;
    e.par  = p;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2);
    in_data = {d2, d1, d0};
  endtask

  // Monitor: every word taken downstream must match the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got data=%0d ch=%0d want none",
                 out_data, out_ch);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_ch", 32'(out_ch), 32'(e.ch));
`ifdef LOGIC_MUXN_PARITY_EN
        chk("out_parity", 32'(out_parity), 32'(e.par));
`endif
      end
    end
  end

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    set_data(3'd0, 3'd0, 3'd0);
    step();
    in_valid = 3'b111;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    in_valid = '0;
    step();
    rst = 1'b0;
    step();

    // Fixed select sel=2
    mode = 1'b0;
    sel  = 2'd2;
    set_data(3'd1, 3'd2, 3'd7);
    in_valid = 3'b100;
    #1;
    chk("fixed_in_ready", 32'(in_ready), 32'b100);
    push(3'd7, 2'd2, 1'b1);
    step();
    in_valid = '0;
    chk("fixed_out_valid", 32'(out_valid), 1);
    sel = 2'd1;
    #1;
    chk("fixed_ready_no_valid", 32'(in_ready), 32'b010);
    step();
    chk("fixed_bubble", 32'(out_valid), 0);

    // Round-robin fairness, all valid
    mode = 1'b1;
    set_data(3'd1, 3'd2, 3'd3);
    in_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      push(W'((k % 3) + 1), S'(k % 3), (k % 3) != 2);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_no_bubble", 32'(out_valid), 1);
    end
    in_valid = '0;
    step();

    // RR skip: move rr_ptr to 1, then only ch0/ch2 valid
    set_data(3'd5, 3'd0, 3'd0);
    in_valid = 3'b001;
    push(3'd5, 2'd0, 1'b0);
    step();
    set_data(3'd1, 3'd0, 3'd4);
    in_valid = 3'b101;
    push(3'd4, 2'd2, 1'b1);
    step();
    in_valid = 3'b001;
    push(3'd1, 2'd0, 1'b1);
    step();
    set_data(3'd0, 3'd6, 3'd3);
    in_valid = 3'b110;
    push(3'd6, 2'd1, 1'b0);
    step();
    in_valid = '0;
    step();

    // Backpressure: hold 5 for 3 cycles with a pending 6
    mode = 1'b0;
    sel  = 2'd0;
    set_data(3'd5, 3'd0, 3'd0);
    in_valid = 3'b001;
    push(3'd5, 2'd0, 1'b0);
    step();
    out_ready = 1'b0;
    set_data(3'd6, 3'd0, 3'd0);
    push(3'd6, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_data", 32'(out_data), 5);
      chk("stall_in_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", 32'(in_ready), 32'b001);
    step();
    in_valid = '0;
    chk("drain_new_data", 32'(out_data), 6);
    step();

    // Out-of-range select
    sel = 2'd1;
    set_data(3'd2, 3'd3, 3'd4);
    in_valid = 3'b111;
    push(3'd3, 2'd1, 1'b0);
    step();
    sel = 2'd3;
    #1;
    chk("oor_in_ready", 32'(in_ready), 0);
    step();
    chk("oor_out_valid", 32'(out_valid), 0);
    in_valid = '0;
    step();

    // Reset mid-stream with a held word
    out_ready = 1'b0;
    sel = 2'd0;
    set_data(3'd6, 3'd0, 3'd0);
    in_valid = 3'b001;
    step();
    chk("pre_rst_data", 32'(out_data), 6);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    chk("async_rst_in_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0;
    mode = 1'b1;
    out_ready = 1'b1;
    set_data(3'd1, 3'd2, 3'd3);
    in_valid = 3'b111;
    push(3'd1, 2'd0, 1'b1);
    step();
    in_valid = '0;
    step();
    step();

    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
